// File: rtl/matrix_pkg.sv
// Shared types and index helpers for the sequential matrix multiplier.
// Flat-index helpers map (row, column) onto row-major packed vectors.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Result width that can hold any sum of n full-width products.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_a(input int r, input int c, input int n_columns);
    return r * n_columns + c;
  endfunction

  function automatic int idx_b(input int r, input int c, input int p_columns);
    return r * p_columns + c;
  endfunction

  function automatic int idx_c(input int r, input int c, input int p_columns);
    return r * p_columns + c;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac.sv
// Shared multiply-accumulate: combinational product plus registered accumulator.
// MATRIX_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module mac_unit #(
  parameter int data_width = 3,
  parameter int acc_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [acc_width-1:0]  sum,
  output logic [acc_width-1:0]  acc
);

  localparam int PW = 2 * data_width;

  logic [acc_width-1:0] prod;

`ifdef MATRIX_SIGNED_EN
  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod_full;

  always_comb begin
    a_x       = PW'($signed(a));
    b_x       = PW'($signed(b));
    prod_full = a_x * b_x;
    prod      = acc_width'(prod_full);
  end
`else
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod_full;

  always_comb begin
    a_x       = PW'(a);
    b_x       = PW'(b);
    prod_full = a_x * b_x;
    prod      = acc_width'(prod_full);
  end
`endif

  assign sum = acc + prod;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) acc <= '0;
    else if (en)         acc <= sum;
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential C = A * B using one shared MAC, iterating row i, column j, inner k.
// Signedness follows MATRIX_SIGNED_EN (see mac_unit).
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int m_rows     = 3,
  parameter int n_columns  = 3,
  parameter int p_columns  = 3,
  parameter int data_width = 3,
  parameter int acc_width  = acc_w(data_width, n_columns)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [m_rows*n_columns*data_width-1:0] matrix_a,
  input  logic [n_columns*p_columns*data_width-1:0] matrix_b,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [m_rows*p_columns*acc_width-1:0]  outp,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int IW = cnt_w(m_rows);
  localparam int JW = cnt_w(p_columns);
  localparam int KW = cnt_w(n_columns);
  localparam logic [IW-1:0] I_LAST = IW'(m_rows - 1);
  localparam logic [JW-1:0] J_LAST = JW'(p_columns - 1);
  localparam logic [KW-1:0] K_LAST = KW'(n_columns - 1);

  state_t state;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic [m_rows*n_columns*data_width-1:0]    a_r;
  logic [n_columns*p_columns*data_width-1:0] b_r;

  logic [data_width-1:0] a_el;
  logic [data_width-1:0] b_el;
  logic [acc_width-1:0]  mac_sum;
  logic [acc_width-1:0]  mac_acc;
  logic                  mac_clear;
  logic                  mac_en;

  always_comb begin
    a_el = a_r[idx_a(int'(i), int'(k), n_columns) * data_width +: data_width];
    b_el = b_r[idx_b(int'(k), int'(j), p_columns) * data_width +: data_width];
  end

  // Accumulator restarts at each output element and whenever idle.
  assign mac_clear = (state != CALC) || (k == K_LAST);
  assign mac_en    = (state == CALC);

  mac_unit #(
    .data_width(data_width),
    .acc_width (acc_width)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(mac_clear),
    .en   (mac_en),
    .a    (a_el),
    .b    (b_el),
    .sum  (mac_sum),
    .acc  (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      outp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= matrix_a;
            b_r      <= matrix_b;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (k == K_LAST) begin
            outp[idx_c(int'(i), int'(j), p_columns) * acc_width +: acc_width] <= mac_sum;
            k <= '0;
            if (j == J_LAST) begin
              j <= '0;
              if (i == I_LAST) begin
                i         <= '0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq: default 3x3x3 instance plus a 2x4x2 instance.
// Expected C values are hand-computed; MATRIX_SIGNED_EN changes a few of them.
module tb_matrix_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [26:0] matrix_a, matrix_b;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [71:0] outp;

  logic [23:0] matrix_a2, matrix_b2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] outp2;

  int checks = 0;
  int errors = 0;
  logic [71:0] sbq[$];

  matrix_mult_seq u_dut (
    .clk(clk), .rst_n(rst_n), .matrix_a(matrix_a), .matrix_b(matrix_b),
    .in_valid(in_valid), .in_ready(in_ready), .outp(outp),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  matrix_mult_seq #(.m_rows(2), .n_columns(4), .p_columns(2), .data_width(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .matrix_a(matrix_a2), .matrix_b(matrix_b2),
    .in_valid(in_valid2), .in_ready(in_ready2), .outp(outp2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] pk_ab(input int v[9]);
    logic [26:0] r;
    r = '0;
    for (int e = 0; e < 9; e++) r[e*3 +: 3] = v[e][2:0];
    return r;
  endfunction

  function automatic logic [71:0] pk_c(input int v[9]);
    logic [71:0] r;
    r = '0;
    for (int e = 0; e < 9; e++) r[e*8 +: 8] = v[e][7:0];
    return r;
  endfunction

  // Monitor: pops an expected result at every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", outp, 72'h0);
      end else begin
        logic [71:0] e;
        e = sbq.pop_front();
        chk("result", outp, e);
      end
    end
  end

  // Waits for the accept edge; inputs change #1 after posedge.
  task automatic accept_job(input logic push, input logic [71:0] exp, input logic drop_valid);
    int guard;
    logic rdy;
    guard = 0;
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        $display("FAIL accept_timeout got %0d want <=500", guard);
        $fatal(1, "accept timeout");
      end
    end
    if (push) sbq.push_back(exp);
    if (drop_valid) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 72'(lat), 72'(exp_lat));
  endtask

  int va[9], vb[9], vc[9];
  logic [71:0] exp1;
  logic seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    matrix_a = '0; matrix_b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; matrix_a2 = '0; matrix_b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 72'(out_valid), 72'd0);
    chk("reset_in_ready", 72'(in_ready), 72'd1);
    chk("reset_outp", outp, 72'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity times 1..9; 8 and 9 wrap to 0 and 1 in 3 bits.
    va = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`ifdef MATRIX_SIGNED_EN
    vc = '{1, 2, 3, -4, -3, -2, -1, 0, 1};
`else
    vc = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
`endif
    matrix_a = pk_ab(va); matrix_b = pk_ab(vb);
    accept_job(1'b1, pk_c(vc), 1'b1);
    wait_done(27);
    @(posedge clk); #1;

    // All sevens: 3*49 = 147 unsigned; 7 reads as -1 signed.
    va = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`ifdef MATRIX_SIGNED_EN
    vc = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
`else
    vc = '{147, 147, 147, 147, 147, 147, 147, 147, 147};
`endif
    matrix_a = pk_ab(va); matrix_b = pk_ab(va);
    accept_job(1'b1, pk_c(vc), 1'b1);
    wait_done(27);
    @(posedge clk); #1;

    // Mixed pattern held in DONE with out_ready low and in_valid high.
    va = '{1, 2, 3, 0, 1, 0, 2, 0, 1};
    vb = '{1, 0, 1, 0, 2, 0, 1, 1, 0};
    vc = '{4, 7, 1, 0, 2, 0, 3, 1, 2};
    exp1 = pk_c(vc);
    out_ready = 1'b0;
    matrix_a = pk_ab(va); matrix_b = pk_ab(vb);
    accept_job(1'b1, exp1, 1'b0);
    wait_done(27);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 0) begin
        chk("hold_out_valid", 72'(out_valid), 72'd1);
        chk("hold_in_ready", 72'(in_ready), 72'd0);
        chk("hold_outp", outp, exp1);
      end
    end
    // Next job: all 4s (or -4s) give 3*16 = 48 in both modes.
    va = '{4, 4, 4, 4, 4, 4, 4, 4, 4};
    vc = '{48, 48, 48, 48, 48, 48, 48, 48, 48};
    matrix_a = pk_ab(va); matrix_b = pk_ab(va);
    out_ready = 1'b1;
    accept_job(1'b1, pk_c(vc), 1'b1);
    wait_done(27);
    @(posedge clk); #1;
    chk("queue_drained_mid", 72'(sbq.size()), 72'd0);

    // Reset during CALC aborts the job.
    va = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    matrix_a = pk_ab(va); matrix_b = pk_ab(va);
    accept_job(1'b0, 72'h0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", 72'(out_valid), 72'd0);
    chk("abort_outp", outp, 72'h0);
    chk("abort_in_ready", 72'(in_ready), 72'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (35) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("abort_no_valid", 72'(seen), 72'd0);

    // 2x4x2 instance, all ones: each C element is 4, latency 16.
    for (int e = 0; e < 8; e++) begin
      matrix_a2[e*3 +: 3] = 3'd1;
      matrix_b2[e*3 +: 3] = 3'd1;
    end
    begin
      int lat2;
      logic rdy2;
      in_valid2 = 1'b1;
      rdy2 = in_ready2;
      @(posedge clk); #1;
      chk("dut2_accept", 72'(rdy2), 72'd1);
      in_valid2 = 1'b0;
      lat2 = 0;
      while (!out_valid2 && lat2 < 100) begin
        @(posedge clk); #1;
        lat2++;
      end
      chk("dut2_latency", 72'(lat2), 72'd16);
      chk("dut2_result", 72'(outp2), 72'h04040404);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained_end", 72'(sbq.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got timeout want finish");
    $fatal(1, "global timeout");
  end

endmodule
